m_muldiv: RTL and testbench
===========================

# m_muldiv

Iterative RV32M/RV64M multiply-divide unit, parametrised in data width. It replaces the single-cycle `*` and `/` paths in the ALU with a shared, area-cheap shift-add / restoring-divide engine that covers all eight M-extension ops. The decoder FSM launches it from EX_R with a start/busy/done handshake and holds the stage until `done`.

## Interface
- `XLEN`, default 32: operand and result width; legal values 8..64.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: launch request. Accepted only on an edge where `busy`=0.
- `op`  in  3: operation, RISC-V funct3 encoding. MUL=000, MULH=001, MULHSU=010, MULHU=011, DIV=100, DIVU=101, REM=110, REMU=111.
- `a`  in  XLEN: rs1 value, sampled only at the accepting edge.
- `b`  in  XLEN: rs2 value, sampled only at the accepting edge.
- `busy`  out  1: operation in flight; `start` is ignored while high.
- `done`  out  1: single-cycle pulse; `result` is valid in this cycle.
- `result`  out  XLEN: final value. Held stable from `done` until the next accepted start.

## Operation
- FSM states: IDLE, CALC, FIN.
  - IDLE: `start` goes to CALC, or to FIN on the fast path.
  - CALC: runs for exactly XLEN cycles, then goes to FIN.
  - FIN: lasts one cycle and drives `done`=1 and `busy`=0. `start` is accepted in FIN, which gives back-to-back operation. Without `start`, FIN goes to IDLE.
- Accepting edge actions:
  - Latch `op`.
  - Latch |a| and |b|. Signedness per op: MULH, DIV and REM treat both operands as signed. MULHSU treats `a` as signed and `b` as unsigned. All other ops treat both as unsigned.
  - Latch the result sign: sign(a)^sign(b) for MUL* and DIV; sign(a) for REM.
  - Clear the iteration counter, which is $clog2(XLEN)+1 bits wide.
- Multiply: one multiplier bit per CALC cycle into a 2·XLEN accumulator. In FIN, conditionally negate the full 2·XLEN product, then select the result:
  - MUL returns the low XLEN bits.
  - MULH, MULHSU and MULHU return the high XLEN bits.
- Divide: restoring division, one quotient bit per CALC cycle, using an XLEN+1-bit partial remainder. In FIN, conditionally negate, then select:
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
- Fast path (IDLE or FIN to FIN, no CALC cycles):
  - Divide by zero (b==0): DIV and DIVU return all-ones; REM and REMU return `a`.
  - Signed overflow (DIV or REM, a==most-negative, b==all-ones): DIV returns `a`; REM returns 0.
- `rst` aborts any operation. No `done` is produced for the aborted operation.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0.
- Normal ops, with the accepting edge taken as E0:
  - `busy`=1 for the XLEN cycles after E0.
  - `done`=1 in the cycle after edge E0+XLEN.
  - Total latency is XLEN+1 cycles; 33 cycles for XLEN=32.
- Fast-path ops: `done`=1 in the cycle after E0, with `busy` never asserted. Latency is 1 cycle.
- `done` is never high for two consecutive cycles unless a new start is accepted in FIN.
- `start` while `busy`=1 is dropped silently; the in-flight result is unaffected.
- `rst` has priority over `start` on the same edge.

## Structure
- Package `muldiv_pkg`:
  - `muldiv_op_t` enum with the eight funct3 codes.
  - `muldiv_state_t` enum {IDLE, CALC, FIN}.
  - Helper function `is_signed_a(op)`.
- Sub-module `m_muldiv_fix`: combinational. Performs the conditional two's-complement negate of the 2·XLEN value and the result select. It is reused in FIN only.
- Top block `m_muldiv`: contains the FSM, the counter and the datapath registers.

## Test plan
- Multiply, XLEN=32:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB; `done` exactly 33 cycles after the accepting edge.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide, a=0xFFFFFFF9, b=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU → 0x7FFFFFFC.
  - REMU → 1.
- Fast path, each with `done` 1 cycle after start and `busy` never high:
  - DIV 5/0 → 0xFFFFFFFF; REM 5%0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Handshake:
  - A `start` pulse with new operands at cycle 5 of a running MUL is ignored; the first result is unchanged.
  - A `start` in the FIN cycle launches the next op, and its `done` arrives 33 cycles later.
- Reset: assert `rst` at cycle 10 of a DIV. Required response: `busy`=0, `result`=0 and state IDLE next cycle, and no `done` ever appears for the aborted DIV.
- XLEN=8 instance:
  - DIV 0x80/0x03 → 0xD6 (−42), with `done` 9 cycles after the accepting edge.
  - REM → 0xFE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and operand helpers for the iterative multiply-divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } muldiv_state_t;

    // rs1 is taken as two's complement for the signed-high multiplies and signed divides
    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is signed only when both operands are signed; MULHSU keeps it unsigned
    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // funct3 bit 2 separates the divide family from the multiply family
    function automatic logic is_div_op(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/m_muldiv_fix.sv
// rtl/m_muldiv_fix.sv - sign restore and result select applied in the final cycle
module m_muldiv_fix
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] value_i,
    input  logic              neg_i,
    input  logic [2:0]        op_i,
    output logic [XLEN-1:0]   result_o
);

    logic [2*XLEN-1:0] prod_fixed;
    logic [XLEN-1:0]   div_sel;
    logic [XLEN-1:0]   div_fixed;

    // Multiplies negate the whole double-width product; divides negate only the half they return,
    // because quotient and remainder carry independent signs.
    always_comb begin
        prod_fixed = neg_i ? -value_i : value_i;
        div_sel    = (op_i == OP_REM || op_i == OP_REMU) ? value_i[2*XLEN-1:XLEN]
                                                         : value_i[XLEN-1:0];
        div_fixed  = neg_i ? -div_sel : div_sel;
        if (is_div_op(op_i)) begin
            result_o = div_fixed;
        end else if (op_i == OP_MUL) begin
            result_o = prod_fixed[XLEN-1:0];
        end else begin
            result_o = prod_fixed[2*XLEN-1:XLEN];
        end
    end

endmodule

// File: rtl/m_muldiv.sv
// rtl/m_muldiv.sv - iterative shift-add multiplier / restoring divider with start/busy/done handshake
module m_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_CALC = CALC;
    localparam logic [1:0] ST_FIN  = FIN;

    logic [1:0]        state_q,  state_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic              neg_q,    neg_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;
    logic [XLEN-1:0]   b_q,      b_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              sa, sb, neg_start;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast;
    logic [2*XLEN-1:0] fast_acc;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_part, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   fix_result;

    // Start is honoured whenever the engine is not iterating, which includes the done cycle.
    assign accept = start_i && (state_q != ST_CALC);

    // Operand conditioning at the accepting edge: magnitudes, result sign and the fast-path cases.
    always_comb begin
        sa        = is_signed_a(op_i) & a_i[XLEN-1];
        sb        = is_signed_b(op_i) & b_i[XLEN-1];
        a_mag     = sa ? -a_i : a_i;
        b_mag     = sb ? -b_i : b_i;
        neg_start = (op_i == OP_REM) ? sa : (sa ^ sb);
        div_zero  = is_div_op(op_i) && (b_i == '0);
        div_ovf   = (op_i == OP_DIV || op_i == OP_REM) && (a_i == MOST_NEG) && (b_i == '1);
        fast      = div_zero || div_ovf;
        // Fast results are parked as {remainder, quotient} so the final-cycle select needs no bypass.
        fast_acc  = div_zero ? {a_i, {XLEN{1'b1}}} : {{XLEN{1'b0}}, a_i};
    end

    // One iteration step for each family: add-and-shift-right, or trial-subtract-and-shift-left.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};
        div_part = acc_q[2*XLEN-1:XLEN-1];
        div_diff = div_part - {1'b0, b_q};
        div_ge   = ~div_diff[XLEN];
        div_next = {(div_ge ? div_diff[XLEN-1:0] : div_part[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
    end

    m_muldiv_fix #(
        .XLEN(XLEN)
    ) u_fix (
        .value_i  (acc_q),
        .neg_i    (neg_q),
        .op_i     (op_q),
        .result_o (fix_result)
    );

    // Next-state logic: iterate for XLEN cycles, publish in FIN, and let a new start override.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: ;
            ST_CALC: begin
                acc_d = is_div_op(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                result_d = fix_result;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            op_d    = op_i;
            neg_d   = fast ? 1'b0 : neg_start;
            b_d     = b_mag;
            cnt_d   = '0;
            acc_d   = fast ? fast_acc : {{XLEN{1'b0}}, a_mag};
            state_d = fast ? ST_FIN : ST_CALC;
        end
    end

    // State and datapath registers; reset drops any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == ST_CALC);
    assign done_o   = (state_q == ST_FIN);
    assign result_o = (state_q == ST_FIN) ? fix_result : result_q;

endmodule

// File: tb/tb_m_muldiv.sv
// tb/tb_m_muldiv.sv - self-checking bench for m_muldiv at XLEN=32 and XLEN=8
module tb_m_muldiv;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic        clk = 1'b0;
    logic        start_s [2];
    logic        rst_s   [2];
    logic [2:0]  op_s    [2];
    logic [31:0] a_s     [2];
    logic [31:0] b_s     [2];
    logic        busy32, done32, busy8, done8;
    logic [31:0] res32;
    logic [7:0]  res8;

    always #5 clk = ~clk;

    m_muldiv #(.XLEN(32)) u_dut32 (
        .clk_i(clk), .rst_i(rst_s[0]), .start_i(start_s[0]), .op_i(op_s[0]),
        .a_i(a_s[0]), .b_i(b_s[0]), .busy_o(busy32), .done_o(done32), .result_o(res32)
    );

    m_muldiv #(.XLEN(8)) u_dut8 (
        .clk_i(clk), .rst_i(rst_s[1]), .start_i(start_s[1]), .op_i(op_s[1]),
        .a_i(a_s[1][7:0]), .b_i(b_s[1][7:0]), .busy_o(busy8), .done_o(done8), .result_o(res8)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // Behavioural reference: plain 64-bit arithmetic on the architectural meaning of each op.
    function automatic logic [31:0] model(int xl, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint mask, ua, ub, sa, sb, p, half;
        mask = (longint'(1) << xl) - 1;
        half = longint'(1) << (xl - 1);
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        sa = (ua >= half) ? ua - (longint'(1) << xl) : ua;
        sb = (ub >= half) ? ub - (longint'(1) << xl) : ub;
        case (op)
            MUL:    p = ua * ub;
            MULH:   p = (sa * sb) >> xl;
            MULHSU: p = (sa * ub) >> xl;
            MULHU:  p = (ua * ub) >> xl;
            DIV:    p = (ub == 0) ? -1 : ((sa == -half && sb == -1) ? sa : sa / sb);
            DIVU:   p = (ub == 0) ? -1 : ua / ub;
            REM:    p = (ub == 0) ? ua : ((sa == -half && sb == -1) ? 0 : sa % sb);
            default: p = (ub == 0) ? ua : ua % ub;
        endcase
        return 32'(p & mask);
    endfunction

    function automatic bit is_fast(int xl, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        longint mask, ua, ub;
        mask = (longint'(1) << xl) - 1;
        ua = longint'(a) & mask;
        ub = longint'(b) & mask;
        if (!op[2]) return 1'b0;
        if (ub == 0) return 1'b1;
        return (op == DIV || op == REM) && (ua == (longint'(1) << (xl - 1))) && (ub == mask);
    endfunction

    // Literal expectations attached by the stimulus to the next accepted op of a DUT.
    logic [31:0] pin_res [2];
    int          pin_lat [2];
    int          pin_id  [2];

    // Model state owned by the compare process.
    bit          armed    [2];
    bit          exp_busy [2];
    bit          exp_done [2];
    int          busy_left[2];
    logic [31:0] pending  [2];
    logic [31:0] held     [2];
    int          acc_cyc  [2];
    int          seen_pin [2];
    bit          pin_live [2];
    logic [31:0] live_res [2];
    int          live_lat [2];
    logic        m_busy, m_done;
    logic [31:0] m_res, m_r;
    int          m_xl;

    task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s dut%0d cycle %0d: got %h, expected %h", nm, d, cyc, act, exp);
        end
    endtask

    // Compare process: check this cycle's outputs, then advance the model across the next edge.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            m_xl   = (d == 0) ? 32 : 8;
            m_busy = (d == 0) ? busy32 : busy8;
            m_done = (d == 0) ? done32 : done8;
            m_res  = (d == 0) ? res32 : {24'd0, res8};
            if (armed[d]) begin
                chk("busy", d, {31'd0, m_busy}, {31'd0, exp_busy[d]});
                chk("done", d, {31'd0, m_done}, {31'd0, exp_done[d]});
                if (exp_done[d] || !exp_busy[d]) chk("result", d, m_res, held[d]);
                if (exp_done[d] && pin_live[d]) begin
                    chk("literal_result", d, m_res, live_res[d]);
                    chk("latency", d, cyc - acc_cyc[d], live_lat[d]);
                    pin_live[d] = 1'b0;
                end
            end
            if (rst_s[d]) begin
                armed[d]    = 1'b1;
                exp_busy[d] = 1'b0;
                exp_done[d] = 1'b0;
                busy_left[d] = 0;
                held[d]     = '0;
                pin_live[d] = 1'b0;
            end else if (armed[d] && start_s[d] && !exp_busy[d]) begin
                m_r = model(m_xl, op_s[d], a_s[d], b_s[d]);
                acc_cyc[d] = cyc;
                pin_live[d] = (pin_id[d] != seen_pin[d]);
                seen_pin[d] = pin_id[d];
                live_res[d] = pin_res[d];
                live_lat[d] = pin_lat[d];
                if (is_fast(m_xl, op_s[d], a_s[d], b_s[d])) begin
                    exp_done[d] = 1'b1;
                    held[d]     = m_r;
                end else begin
                    exp_busy[d]  = 1'b1;
                    exp_done[d]  = 1'b0;
                    busy_left[d] = m_xl;
                    pending[d]   = m_r;
                end
            end else if (exp_busy[d]) begin
                busy_left[d]--;
                exp_done[d] = 1'b0;
                if (busy_left[d] == 0) begin
                    exp_busy[d] = 1'b0;
                    exp_done[d] = 1'b1;
                    held[d]     = pending[d];
                end
            end else begin
                exp_done[d] = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pin(int d, logic [31:0] r, int lat);
        pin_res[d] = r;
        pin_lat[d] = lat;
        pin_id[d]  = pin_id[d] + 1;
    endtask

    task automatic drive(int d, logic [2:0] op, logic [31:0] a, logic [31:0] b);
        op_s[d] = op;
        a_s[d]  = a;
        b_s[d]  = b;
        start_s[d] = 1'b1;
        tick();
        start_s[d] = 1'b0;
    endtask

    function automatic logic [31:0] pick(int xl);
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return (xl == 32) ? 32'h8000_0000 : 32'h0000_0080;
            4: return 32'd2;
            default: return $urandom;
        endcase
    endfunction

    int          rd, rxl, gap;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    initial begin
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; rst_s[d] = 1'b1; op_s[d] = '0; a_s[d] = '0; b_s[d] = '0;
            pin_res[d] = '0; pin_lat[d] = 0; pin_id[d] = 0;
        end
        repeat (3) tick();
        rst_s[0] = 1'b0;
        rst_s[1] = 1'b0;
        tick();

        // MUL with a start pulse injected mid-flight that must be dropped
        pin(0, 32'hFFFF_FFEB, 33);
        drive(0, MUL, 32'd7, 32'hFFFF_FFFD);
        repeat (3) tick();
        drive(0, MULHU, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (32) tick();

        pin(0, 32'h4000_0000, 33); drive(0, MULH,  32'h8000_0000, 32'h8000_0000); repeat (34) tick();
        pin(0, 32'hFFFF_FFFE, 33); drive(0, MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF); repeat (34) tick();
        pin(0, 32'hFFFF_FFFD, 33); drive(0, DIV,   32'hFFFF_FFF9, 32'd2);         repeat (34) tick();
        pin(0, 32'hFFFF_FFFF, 33); drive(0, REM,   32'hFFFF_FFF9, 32'd2);         repeat (34) tick();
        pin(0, 32'h7FFF_FFFC, 33); drive(0, DIVU,  32'hFFFF_FFF9, 32'd2);         repeat (34) tick();
        pin(0, 32'h0000_0001, 33); drive(0, REMU,  32'hFFFF_FFF9, 32'd2);         repeat (34) tick();

        pin(0, 32'hFFFF_FFFF, 1); drive(0, DIV, 32'd5, 32'd0);                    repeat (3) tick();
        pin(0, 32'h0000_0005, 1); drive(0, REM, 32'd5, 32'd0);                    repeat (3) tick();
        pin(0, 32'h8000_0000, 1); drive(0, DIV, 32'h8000_0000, 32'hFFFF_FFFF);    repeat (3) tick();
        pin(0, 32'h0000_0000, 1); drive(0, REM, 32'h8000_0000, 32'hFFFF_FFFF);    repeat (3) tick();

        // Back-to-back: second start lands in the FIN cycle of the first
        pin(0, 32'hFFFF_FFFF, 33);
        drive(0, MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (32) tick();
        pin(0, 32'h7FFF_FFFC, 33);
        drive(0, DIVU, 32'hFFFF_FFF9, 32'd2);
        repeat (34) tick();

        // Abort a DIV about ten cycles in
        drive(0, DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (8) tick();
        rst_s[0] = 1'b1;
        tick();
        rst_s[0] = 1'b0;
        repeat (40) tick();

        // Narrow instance
        pin(1, 32'h0000_00D6, 9); drive(1, DIV, 32'h80, 32'h03); repeat (10) tick();
        pin(1, 32'h0000_00FE, 9); drive(1, REM, 32'h80, 32'h03); repeat (10) tick();

        // Randomized traffic with random gaps, occasional FIN restarts, drops and resets
        for (int i = 0; i < 300; i++) begin
            rd  = $urandom_range(0, 1);
            rxl = (rd == 0) ? 32 : 8;
            rop = 3'($urandom_range(0, 7));
            ra  = pick(rxl);
            rb  = pick(rxl);
            if ($urandom_range(0, 49) == 0) begin
                rst_s[rd] = 1'b1;
                tick();
                rst_s[rd] = 1'b0;
            end
            drive(rd, rop, ra, rb);
            case ($urandom_range(0, 3))
                0: gap = rxl;
                1: gap = rxl + 1;
                2: gap = $urandom_range(0, rxl + 2);
                default: gap = 0;
            endcase
            repeat (gap) tick();
        end

        repeat (40) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
